ifetch: RTL and testbench

Instruction fetch stage for the mox125 pipeline. Drives fetch addresses into the direct-mapped instruction cache and consumes its combinational hit/instruction/immediate outputs. Computes each instruction's length (2 or 6 bytes) and advances the PC. Queues fetched instructions, with PC and immediate, in a small FIFO that the decode stage drains under a valid/ready handshake; branch redirects flush the queue.

---
 rtl/ifetch_if.sv | 27 ++
 rtl/ifetch.sv | 138 +++++++++++++
 tb/tb_ifetch.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: icache request/response, branch redirect and the
// decode-side valid/ready queue head.
interface ifetch_if;
    logic [31:0] ic_adr_o;
    logic        ic_stb_o;
    logic        ic_hit_i;
    logic [15:0] ic_inst_i;
    logic [31:0] ic_data_i;
    logic        flush_i;
    logic [31:0] flush_adr_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [15:0] inst_o;
    logic [31:0] imm_o;
    logic [31:0] pc_o;
    logic [1:0]  state_o;

    modport master (
        output ic_adr_o, ic_stb_o, inst_valid_o, inst_o, imm_o, pc_o, state_o,
        input  ic_hit_i, ic_inst_i, ic_data_i, flush_i, flush_adr_i, inst_ready_i
    );

    modport slave (
        input  ic_adr_o, ic_stb_o, inst_valid_o, inst_o, imm_o, pc_o, state_o,
        output ic_hit_i, ic_inst_i, ic_data_i, flush_i, flush_adr_i, inst_ready_i
    );
endinterface

// File: rtl/ifetch.sv
// mox125 instruction fetch: walks the PC through the icache, sizes each
// instruction (2 or 6 bytes) and queues {inst, imm, pc} for decode.
module ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h00001000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    ifetch_if.master bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] F_RESET = 2'd0;
    localparam logic [1:0] F_RUN   = 2'd1;
    localparam logic [1:0] F_MISS  = 2'd2;

    logic [1:0]       r_state, w_state_nxt;
    logic [31:0]      r_adr, w_adr_nxt;
    logic             r_stb, w_stb_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [PTR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [PTR_W-1:0] r_rd_ptr, w_rd_ptr_nxt;

    logic [15:0] r_inst_q [FIFO_DEPTH];
    logic [31:0] r_imm_q  [FIFO_DEPTH];
    logic [31:0] r_pc_q   [FIFO_DEPTH];

    logic        w_long;
    logic [31:0] w_imm;
    logic        w_valid;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_flush_tgt;

    // Length decode: listed opcodes carry a 32-bit immediate after the halfword.
    always_comb begin : len_decode
        w_long = 1'b0;
        if (!bus.ic_inst_i[15]) begin
            case (bus.ic_inst_i[15:8])
                8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1D,
                8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39:
                    w_long = 1'b1;
                default:
                    w_long = 1'b0;
            endcase
        end
    end

    assign w_imm       = w_long ? bus.ic_data_i : 32'h0;
    assign w_valid     = (r_count != '0);
    assign w_push      = r_stb & bus.ic_hit_i & ~bus.flush_i;
    assign w_pop       = w_valid & bus.inst_ready_i & ~bus.flush_i;
    assign w_flush_tgt = bus.flush_adr_i & ~32'h1;

    // Next-state logic; a redirect overrides any capture or pop in the same cycle.
    always_comb begin : next_state
        w_state_nxt  = r_state;
        w_adr_nxt    = r_adr;
        w_count_nxt  = r_count;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_stb_nxt    = 1'b0;

        case (r_state)
            F_RESET: w_state_nxt = F_RUN;
            F_RUN:   if (r_stb && !bus.ic_hit_i) w_state_nxt = F_MISS;
            F_MISS:  if (bus.ic_hit_i) w_state_nxt = F_RUN;
            default: w_state_nxt = F_RESET;
        endcase

        if (w_push) begin
            w_adr_nxt    = r_adr + (w_long ? 32'd6 : 32'd2);
            w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        end
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

        if (bus.flush_i) begin
            w_state_nxt  = F_RUN;
            w_adr_nxt    = w_flush_tgt;
            w_count_nxt  = '0;
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end

        // Miss holds the request up; otherwise request whenever there is room.
        if (w_state_nxt == F_MISS) begin
            w_stb_nxt = 1'b1;
        end else if (w_state_nxt == F_RUN) begin
            w_stb_nxt = (w_count_nxt != FULL_CNT);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin : state_reg
        if (!rst_i) begin
            r_state  <= F_RESET;
            r_adr    <= RESET_PC & ~32'h1;
            r_stb    <= 1'b0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_adr    <= w_adr_nxt;
            r_stb    <= w_stb_nxt;
            r_count  <= w_count_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    // Queue storage; writes are already blocked when full since r_stb is low.
    always_ff @(posedge clk_i or negedge rst_i) begin : fifo_mem
        if (!rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_inst_q[i] <= '0;
                r_imm_q[i]  <= '0;
                r_pc_q[i]   <= '0;
            end
        end else if (w_push) begin
            r_inst_q[r_wr_ptr] <= bus.ic_inst_i;
            r_imm_q[r_wr_ptr]  <= w_imm;
            r_pc_q[r_wr_ptr]   <= r_adr;
        end
    end

    assign bus.ic_adr_o     = r_adr;
    assign bus.ic_stb_o     = r_stb;
    assign bus.state_o      = r_state;
    assign bus.inst_valid_o = w_valid;
    assign bus.inst_o       = w_valid ? r_inst_q[r_rd_ptr] : 16'h0;
    assign bus.imm_o        = w_valid ? r_imm_q[r_rd_ptr]  : 32'h0;
    assign bus.pc_o         = w_valid ? r_pc_q[r_rd_ptr]   : 32'h0;
endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus a randomized run
// scored against a program-stream model of fetch and queueing.
module tb_ifetch;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h00001000;
    localparam logic [115:0] RST_OUTS = {RPC & ~32'h1, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 2'd0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   mode     = 0;

    byte unsigned long_ops [17] = '{8'h01, 8'h03, 8'h08, 8'h09, 8'h0C, 8'h0D, 8'h1A, 8'h1B,
                                    8'h1D, 8'h1F, 8'h20, 8'h22, 8'h24, 8'h36, 8'h37, 8'h38, 8'h39};

    ifetch_if bus();

    ifetch #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic bit is_long(logic [15:0] inst);
        if (inst[15]) return 1'b0;
        foreach (long_ops[k]) if (inst[15:8] == long_ops[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] hash(logic [31:0] a);
        logic [31:0] h = a * 32'h9E3779B1;
        return h ^ (h >> 15);
    endfunction

    // Icache contents: mode 0 all short, mode 1 random mix, mode 2 ldi.l at 0x1000.
    function automatic logic [15:0] mem_inst(int m, logic [31:0] a);
        logic [31:0] h = hash(a);
        case (m)
            0:       return {1'b1, a[15:1]};
            2:       return (a == 32'h1000) ? 16'h0100 : 16'h8123;
            default: begin
                if (h[2:0] < 3'd3) return {long_ops[h[12:8] % 17], h[23:16]};
                return h[31:16];
            end
        endcase
    endfunction

    function automatic logic [31:0] mem_data(int m, logic [31:0] a);
        if (m == 2) return 32'hDEADBEEF;
        return hash(a) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] exp_imm(int m, logic [31:0] a);
        return is_long(mem_inst(m, a)) ? mem_data(m, a) : 32'h0;
    endfunction

    function automatic logic [31:0] exp_len(logic [15:0] i);
        return is_long(i) ? 32'd6 : 32'd2;
    endfunction

    function automatic logic [115:0] outs();
        return {bus.ic_adr_o, bus.ic_stb_o, bus.inst_valid_o, bus.inst_o,
                bus.imm_o, bus.pc_o, bus.state_o};
    endfunction

    // Combinational icache: contents follow the requested address.
    initial begin
        forever begin
            bus.ic_inst_i = mem_inst(mode, bus.ic_adr_o);
            bus.ic_data_i = mem_data(mode, bus.ic_adr_o);
            @(bus.ic_adr_o or mode);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic restart(int m);
        mode = m;
        rst_n = 1'b0;
        bus.flush_i = 1'b0;
        bus.flush_adr_i = '0;
        bus.inst_ready_i = 1'b0;
        bus.ic_hit_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_pc;
        mode = 0;
        rst_n = 1'b0;
        bus.ic_hit_i = 1'b1;
        bus.inst_ready_i = 1'b0;
        bus.flush_i = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (outs() !== RST_OUTS) begin
            n_fail++; $display("FAIL reset_values: got %h want %h", outs(), RST_OUTS);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if ({bus.state_o, bus.ic_stb_o, bus.inst_valid_o} !== {2'd1, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL first_stb: got st=%0d stb=%b v=%b want st=1 stb=1 v=0",
                               bus.state_o, bus.ic_stb_o, bus.inst_valid_o);
        end
        bus.inst_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = RPC + 32'(2 * i);
            n_checks++;
            if ({bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.imm_o} !==
                {1'b1, exp_pc, mem_inst(0, exp_pc), 32'h0}) begin
                n_fail++; $display("FAIL reset_seq%0d: got v=%b pc=%h inst=%h imm=%h want pc=%h inst=%h",
                                   i, bus.inst_valid_o, bus.pc_o, bus.inst_o, bus.imm_o,
                                   exp_pc, mem_inst(0, exp_pc));
            end
        end
    endtask

    task automatic test_long_insn();
        restart(2);
        tick();
        tick();
        n_checks++;
        if ({bus.inst_o, bus.imm_o, bus.pc_o, bus.ic_adr_o} !==
            {16'h0100, 32'hDEADBEEF, 32'h1000, 32'h1006}) begin
            n_fail++; $display("FAIL ldi_entry: got inst=%h imm=%h pc=%h adr=%h want 0100 deadbeef 1000 1006",
                               bus.inst_o, bus.imm_o, bus.pc_o, bus.ic_adr_o);
        end
        tick();
        n_checks++;
        if (bus.ic_adr_o !== 32'h1008) begin
            n_fail++; $display("FAIL short_adv: got adr=%h want 00001008", bus.ic_adr_o);
        end
        bus.inst_ready_i = 1'b1;
        tick();
        n_checks++;
        if ({bus.inst_o, bus.imm_o, bus.pc_o} !== {16'h8123, 32'h0, 32'h1006}) begin
            n_fail++; $display("FAIL short_entry: got inst=%h imm=%h pc=%h want 8123 0 1006",
                               bus.inst_o, bus.imm_o, bus.pc_o);
        end
    endtask

    task automatic test_miss();
        bit found = 1'b0;
        restart(0);
        bus.inst_ready_i = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.ic_adr_o == 32'h1010) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL miss_reach: got adr=%h want 00001010 within 20 cycles", bus.ic_adr_o);
        end
        bus.ic_hit_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if ({bus.ic_adr_o, bus.ic_stb_o, bus.state_o, bus.inst_valid_o} !==
                {32'h1010, 1'b1, 2'd2, 1'b0}) begin
                n_fail++; $display("FAIL miss_hold%0d: got adr=%h stb=%b st=%0d v=%b want 1010 1 2 0",
                                   i, bus.ic_adr_o, bus.ic_stb_o, bus.state_o, bus.inst_valid_o);
            end
        end
        bus.ic_hit_i = 1'b1;
        tick();
        n_checks++;
        if ({bus.inst_valid_o, bus.pc_o, bus.state_o, bus.ic_adr_o} !==
            {1'b1, 32'h1010, 2'd1, 32'h1012}) begin
            n_fail++; $display("FAIL miss_resume: got v=%b pc=%h st=%0d adr=%h want 1 1010 1 1012",
                               bus.inst_valid_o, bus.pc_o, bus.state_o, bus.ic_adr_o);
        end
    endtask

    task automatic test_full();
        restart(0);
        tick();
        repeat (4) tick();
        n_checks++;
        if ({bus.ic_stb_o, bus.ic_adr_o, bus.state_o, bus.inst_valid_o, bus.pc_o} !==
            {1'b0, 32'h1008, 2'd1, 1'b1, 32'h1000}) begin
            n_fail++; $display("FAIL full_stop: got stb=%b adr=%h st=%0d v=%b pc=%h want 0 1008 1 1 1000",
                               bus.ic_stb_o, bus.ic_adr_o, bus.state_o, bus.inst_valid_o, bus.pc_o);
        end
        repeat (3) tick();
        n_checks++;
        if ({bus.ic_stb_o, bus.ic_adr_o, bus.pc_o} !== {1'b0, 32'h1008, 32'h1000}) begin
            n_fail++; $display("FAIL full_frozen: got stb=%b adr=%h pc=%h want 0 1008 1000",
                               bus.ic_stb_o, bus.ic_adr_o, bus.pc_o);
        end
        bus.inst_ready_i = 1'b1;
        tick();
        bus.inst_ready_i = 1'b0;
        n_checks++;
        if ({bus.ic_stb_o, bus.pc_o, bus.ic_adr_o} !== {1'b1, 32'h1002, 32'h1008}) begin
            n_fail++; $display("FAIL full_pop: got stb=%b pc=%h adr=%h want 1 1002 1008",
                               bus.ic_stb_o, bus.pc_o, bus.ic_adr_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({bus.ic_stb_o, bus.ic_adr_o} !== {1'b0, 32'h100A}) begin
                n_fail++; $display("FAIL full_one_push%0d: got stb=%b adr=%h want 0 100a",
                                   i, bus.ic_stb_o, bus.ic_adr_o);
            end
        end
        bus.ic_hit_i = 1'b0;
        bus.inst_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({bus.inst_valid_o, bus.pc_o} !== {1'b1, 32'h1002 + 32'(2 * i)}) begin
                n_fail++; $display("FAIL full_drain%0d: got v=%b pc=%h want 1 %h",
                                   i, bus.inst_valid_o, bus.pc_o, 32'h1002 + 32'(2 * i));
            end
            tick();
        end
        n_checks++;
        if (bus.inst_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL full_empty: got v=%b want 0", bus.inst_valid_o);
        end
    endtask

    task automatic test_flush_miss();
        restart(0);
        tick();
        repeat (3) tick();
        bus.ic_hit_i = 1'b0;
        tick();
        n_checks++;
        if ({bus.state_o, bus.ic_stb_o, bus.ic_adr_o, bus.inst_valid_o, bus.pc_o} !==
            {2'd2, 1'b1, 32'h1006, 1'b1, 32'h1000}) begin
            n_fail++; $display("FAIL flush_pre: got st=%0d stb=%b adr=%h v=%b pc=%h want 2 1 1006 1 1000",
                               bus.state_o, bus.ic_stb_o, bus.ic_adr_o, bus.inst_valid_o, bus.pc_o);
        end
        bus.flush_i = 1'b1;
        bus.flush_adr_i = 32'h2001;
        bus.inst_ready_i = 1'b1;
        bus.ic_hit_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        n_checks++;
        if ({bus.inst_valid_o, bus.ic_adr_o, bus.state_o, bus.ic_stb_o, bus.inst_o, bus.imm_o, bus.pc_o} !==
            {1'b0, 32'h2000, 2'd1, 1'b1, 16'h0, 32'h0, 32'h0}) begin
            n_fail++; $display("FAIL flush_next: got v=%b adr=%h st=%0d stb=%b pc=%h want 0 2000 1 1 0",
                               bus.inst_valid_o, bus.ic_adr_o, bus.state_o, bus.ic_stb_o, bus.pc_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if ({bus.inst_valid_o, bus.pc_o} !== {1'b1, 32'h2000 + 32'(2 * i)}) begin
                n_fail++; $display("FAIL flush_new%0d: got v=%b pc=%h want 1 %h",
                                   i, bus.inst_valid_o, bus.pc_o, 32'h2000 + 32'(2 * i));
            end
        end
    endtask

    task automatic test_reset_mid();
        restart(0);
        tick();
        repeat (2) tick();
        n_checks++;
        if ({bus.inst_valid_o, bus.pc_o} !== {1'b1, 32'h1000}) begin
            n_fail++; $display("FAIL mid_prefill: got v=%b pc=%h want 1 1000", bus.inst_valid_o, bus.pc_o);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (outs() !== RST_OUTS) begin
            n_fail++; $display("FAIL mid_async_reset: got %h want %h", outs(), RST_OUTS);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.inst_valid_o, bus.pc_o, bus.ic_adr_o} !== {1'b1, 32'h1000, 32'h1002}) begin
            n_fail++; $display("FAIL mid_restart: got v=%b pc=%h adr=%h want 1 1000 1002",
                               bus.inst_valid_o, bus.pc_o, bus.ic_adr_o);
        end
    endtask

    // Model: the program is a stream walked from the PC by instruction length;
    // decode must see exactly that stream, in order, restarted at every redirect.
    task automatic test_random();
        logic [79:0] q[$];
        logic [31:0] m_pc = RPC;
        logic [31:0] fa;
        logic [15:0] mi;
        bit started = 1'b0;
        bit pending = 1'b0;
        bit exp_stb, h, r, f;
        restart(1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            h  = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 9) < 6);
            f  = ($urandom_range(0, 99) < 3);
            fa = $urandom;
            bus.ic_hit_i = h;
            bus.inst_ready_i = r;
            bus.flush_i = f;
            bus.flush_adr_i = fa;
            exp_stb = started && (pending || q.size() != DEPTH);
            n_checks++;
            if ({bus.ic_stb_o, bus.ic_adr_o} !== {exp_stb, m_pc}) begin
                n_fail++; $display("FAIL rnd_fetch c%0d: got stb=%b adr=%h want stb=%b adr=%h",
                                   cyc, bus.ic_stb_o, bus.ic_adr_o, exp_stb, m_pc);
            end
            n_checks++;
            if (bus.inst_valid_o !== (q.size() != 0)) begin
                n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, bus.inst_valid_o, q.size() != 0);
            end
            if (q.size() != 0) begin
                n_checks++;
                if ({bus.inst_o, bus.imm_o, bus.pc_o} !== q[0]) begin
                    n_fail++; $display("FAIL rnd_head c%0d: got %h want %h",
                                       cyc, {bus.inst_o, bus.imm_o, bus.pc_o}, q[0]);
                end
            end
            if (f) begin
                q.delete();
                m_pc = fa & ~32'h1;
                pending = 1'b0;
            end else begin
                if (r && q.size() != 0) void'(q.pop_front());
                if (exp_stb && h) begin
                    mi = mem_inst(1, m_pc);
                    q.push_back({mi, exp_imm(1, m_pc), m_pc});
                    m_pc = m_pc + exp_len(mi);
                    pending = 1'b0;
                end else if (exp_stb) begin
                    pending = 1'b1;
                end
            end
            started = 1'b1;
            tick();
        end
    endtask

    initial begin
        bus.ic_hit_i = 1'b0;
        bus.inst_ready_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.flush_adr_i = '0;
        test_reset();
        test_long_insn();
        test_miss();
        test_full();
        test_flush_miss();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
